// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte streams.
// Packets (bytes until req_last) hold the grant; each byte is paced by uart_tx_busy.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int BUSY_TO = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_send,
    output logic [7:0]        uart_txd,
    input  logic              uart_tx_busy,
    output logic [NREQ-1:0]   grant,
    output logic              active,
    output logic              to_err,
    input  logic              err_clr
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BUSY_TO + 1);
    localparam logic [PW:0]   NREQ_W  = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST_ID = PW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BUSY_TO);
    localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TO - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          rr_ptr, lock_own, sel, off;
    logic                   lock_vld, sel_vld, acc, tmo;
    logic [CW-1:0]          cnt;
    logic [PW:0]            sum;
    logic [NREQ-1:0]        rot, sel_oh;
    logic [NREQ-1:0][7:0]   data_a;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_a[g] = req_data[8*g +: 8];
    end

    // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the next in turn.
    assign rot = NREQ'({req_valid, req_valid} >> rr_ptr);

    always_comb begin
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = PW'(k);
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        if (lock_vld) begin
            sel     = lock_own;
            sel_vld = req_valid[lock_own];
        end else begin
            sel     = sum[PW-1:0];
            sel_vld = |req_valid;
        end
    end

    assign sel_oh    = NREQ'(1) << sel;
    assign req_ready = (state == IDLE && rst && sel_vld) ? sel_oh : '0;
    assign acc       = |(req_valid & req_ready);
    assign uart_send = (state == SEND);
    assign active    = (state != IDLE) || lock_vld;

    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        case (state)
            IDLE:      if (acc) state_nxt = SEND;
            SEND:      state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == TO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: if (!uart_tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_own <= '0;
            uart_txd <= 8'h00;
            grant    <= '0;
            cnt      <= '0;
            to_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                uart_txd <= data_a[sel];
                grant    <= sel_oh;
                rr_ptr   <= (sel == LAST_ID) ? '0 : sel + 1'b1;
                lock_vld <= !req_last[sel];
                lock_own <= sel;
            end
            // A timed-out byte is dropped and releases any packet lock.
            if (tmo) lock_vld <= 1'b0;
            if (state == SEND) begin
                cnt <= '0;
            end else if (state == WAIT_BUSY && !uart_tx_busy && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (tmo)          to_err <= 1'b1;
            else if (err_clr) to_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-fed requesters plus a busy-pulse UART stand-in.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*NREQ-1:0] req_data;
    logic              uart_send, uart_tx_busy, active, to_err, err_clr;
    logic [7:0]        uart_txd;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TO(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .uart_send(uart_send),
        .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy), .grant(grant),
        .active(active), .to_err(to_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // requester queues
    logic [8:0] qmem [NREQ][32];
    int         qh [NREQ];
    int         qt [NREQ];
    int         acc_q [$];
    logic [7:0] accd_q [$];
    logic [7:0] tx_q [$];
    int         rdy_bad, rdy_cyc;

    // UART stand-in
    logic model_en = 1'b0;
    int   hold = 4;
    int   m_cnt = -1;

    task automatic push(input int i, input logic [7:0] d, input logic l);
        qmem[i][qt[i]] = {l, d};
        qt[i]++;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (qh[i] < qt[i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        req_valid = '0; req_data = '0; req_last = '0;
        for (int i = 0; i < NREQ; i++) begin qh[i] = 0; qt[i] = 0; end
        forever begin
            logic [NREQ-1:0] am;
            @(negedge clk);
            am = req_valid & req_ready;
            if (req_ready != '0) rdy_cyc++;
            if (am != '0) begin
                if ($countones(req_ready) != 1) rdy_bad++;
                for (int i = 0; i < NREQ; i++)
                    if (am[i]) begin acc_q.push_back(i); accd_q.push_back(req_data[8*i +: 8]); end
            end
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (am[i]) qh[i]++;
                req_valid[i] = (qh[i] < qt[i]);
                if (qh[i] < qt[i]) {req_last[i], req_data[8*i +: 8]} = qmem[i][qh[i]];
                else begin req_last[i] = 1'b0; req_data[8*i +: 8] = 8'h00; end
            end
        end
    end

    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!model_en) begin
                m_cnt = -1; uart_tx_busy = 1'b0;
            end else if (uart_send) begin
                tx_q.push_back(uart_txd); m_cnt = 0;
            end else if (m_cnt >= 0) begin
                m_cnt++;
                if (m_cnt == 3) uart_tx_busy = 1'b1;
                if (m_cnt == 3 + hold) begin uart_tx_busy = 1'b0; m_cnt = -1; end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0; model_en = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < NREQ; i++) begin qh[i] = 0; qt[i] = 0; end
        repeat (2) @(posedge clk); #1;
        acc_q.delete(); accd_q.delete(); tx_q.delete(); rdy_bad = 0; rdy_cyc = 0;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (n < maxc) begin
            @(negedge clk);
            if (all_empty() && !active && !uart_tx_busy) break;
            n++;
        end
        chk("drain", 32'(n < maxc), 32'd1);
    endtask

    task automatic wait_busy(input logic lvl, input int maxc);
        int n;
        n = 0;
        while (n < maxc) begin
            @(negedge clk);
            if (uart_tx_busy == lvl) break;
            n++;
        end
        chk("busy_wait", 32'(n < maxc), 32'd1);
    endtask

    initial begin
        logic [7:0] rnd [2][8];
        logic [7:0] exp_d [6];
        int         exp_i [6];
        int         n;
        err_clr = 1'b0;

        // single byte, reset values
        do_reset();
        model_en = 1'b1; hold = 20;
        push(0, 8'hA5, 1'b1);
        @(negedge clk); @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_send", uart_send, 0);
        chk("rst_txd", uart_txd, 0);
        chk("rst_grant", grant, 0);
        chk("rst_active", active, 0);
        chk("rst_toerr", to_err, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("t1_send", uart_send, 1);
        chk("t1_txd", uart_txd, 8'hA5);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_ready_off", req_ready, 0);
        @(negedge clk); chk("t1_pulse", uart_send, 0);
        wait_busy(1'b1, 50);
        wait_busy(1'b0, 50);
        chk("t1_wait_done", active, 1);
        @(negedge clk); chk("t1_idle", active, 0);
        wait_drain(50);
        chk("t1_rdy_cyc", rdy_cyc, 1);
        chk("t1_tx_n", tx_q.size(), 1);
        if (tx_q.size() > 0) chk("t1_tx", tx_q[0], 8'hA5);

        // round-robin
        do_reset();
        model_en = 1'b1; hold = 4;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NREQ; i++) push(i, 8'(16*i + k), 1'b1);
        release_rst();
        wait_drain(400);
        chk("rr_n", acc_q.size(), 8);
        for (int k = 0; k < 6 && k < acc_q.size(); k++) chk("rr_order", acc_q[k], k % 4);
        chk("rr_onehot", rdy_bad, 0);
        for (int k = 0; k < tx_q.size() && k < accd_q.size(); k++) chk("rr_tx", tx_q[k], accd_q[k]);

        // packet lock: req1 first to put rr_ptr at 2
        do_reset();
        model_en = 1'b1; hold = 4;
        push(1, 8'h01, 1'b1);
        release_rst();
        wait_drain(100);
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        push(0, 8'hAA, 1'b1); push(1, 8'hBB, 1'b1);
        wait_drain(400);
        exp_i = '{1, 2, 2, 2, 0, 1};
        exp_d = '{8'h01, 8'h11, 8'h22, 8'h33, 8'hAA, 8'hBB};
        chk("lk_n", tx_q.size(), 6);
        for (int k = 0; k < 6 && k < acc_q.size(); k++) chk("lk_order", acc_q[k], exp_i[k]);
        for (int k = 0; k < 6 && k < tx_q.size(); k++) chk("lk_tx", tx_q[k], exp_d[k]);

        // timeout with busy never rising
        do_reset();
        push(0, 8'h5A, 1'b0); push(1, 8'h6B, 1'b1);
        release_rst();
        @(negedge clk); chk("to_ready0", req_ready, 4'b0001);
        repeat (17) @(negedge clk);
        chk("to_early", to_err, 0);
        chk("to_busy_wait", active, 1);
        @(negedge clk);
        chk("to_set", to_err, 1);
        chk("to_unlock", active, 0);
        chk("to_next", req_ready, 4'b0010);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk); chk("to_clr", to_err, 0);
        repeat (14) @(negedge clk);
        @(posedge clk); #1 err_clr = 1'b1;
        @(negedge clk); chk("to_pre_set", to_err, 0);
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk); chk("to_set_wins", to_err, 1);

        // reset in WAIT_DONE of byte 2 of a locked packet
        do_reset();
        model_en = 1'b1; hold = 6;
        push(0, 8'h31, 1'b0); push(0, 8'h32, 1'b0); push(0, 8'h33, 1'b1);
        push(2, 8'h50, 1'b1);
        release_rst();
        n = 0;
        while (tx_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
        chk("mr_two_sent", tx_q.size(), 2);
        wait_busy(1'b1, 50);
        @(negedge clk);
        chk("mr_pre", active, 1);
        #3 rst = 1'b0; model_en = 1'b0;
        #1;
        chk("mr_send", uart_send, 0);
        chk("mr_txd", uart_txd, 0);
        chk("mr_grant", grant, 0);
        chk("mr_active", active, 0);
        chk("mr_ready", req_ready, 0);
        qh[0] = qt[0];
        push(3, 8'h60, 1'b1);
        repeat (2) @(posedge clk); #1 model_en = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); chk("mr_regrant", req_ready, 4'b0100);
        wait_drain(200);

        // two streams of random bytes through the busy stand-in
        do_reset();
        model_en = 1'b1; hold = 5;
        for (int k = 0; k < 8; k++) begin
            rnd[0][k] = 8'($urandom);
            rnd[1][k] = 8'($urandom);
            push(0, rnd[0][k], 1'b1);
            push(1, rnd[1][k], 1'b1);
        end
        release_rst();
        wait_drain(1000);
        chk("lb_n", tx_q.size(), 16);
        for (int k = 0; k < 16 && k < tx_q.size(); k++) begin
            chk("lb_src", acc_q[k], k % 2);
            chk("lb_tx", tx_q[k], rnd[k % 2][k / 2]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART_IP transmitter among NREQ byte-stream requesters (CPU console, debug monitor, DMA log, etc.). It accepts bytes over per-requester valid/ready handshakes and drives the UART_IP SEND/TX data inputs. It sequences each byte against the transmitter's TxBusy. Packets marked with a last flag are kept contiguous on the line by locking the grant to one requester.

## Interface
- NREQ, 4, number of requesters (2..8)
- BUSY_TO, 16, cycles to wait for uart_tx_busy to rise after a send pulse before declaring a timeout (>=2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a byte
- req_data  in  8*NREQ  byte for requester i at bits [8i+7:8i]
- req_last  in  NREQ  byte is last of its packet
- req_ready  out  NREQ  combinational; byte accepted when req_valid[i]&req_ready[i]
- uart_send  out  1  one-cycle send strobe to UART_IP SEND
- uart_txd  out  8  byte to UART_IP TX data, held stable until next acceptance
- uart_tx_busy  in  1  UART_IP TxBusy
- grant  out  NREQ  one-hot owner of the current or last accepted byte
- active  out  1  high whenever state != IDLE or a lock is held
- to_err  out  1  sticky timeout flag
- err_clr  in  1  clears to_err

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE, no lock:
  - Select the first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
  - req_ready is high only for the selected i. All other bits are 0.
- IDLE, lock held by owner o: only o is eligible. req_ready[o] = req_valid[o] and all other bits are 0. There is no preemption. An idle owner stalls all others indefinitely.
- Acceptance on valid&ready:
  - Register uart_txd <= data, grant <= onehot(i), rr_ptr <= (i+1) mod NREQ.
  - Set lock to owner i if req_last[i]=0. Clear lock if req_last[i]=1.
  - Go to SEND.
- SEND: uart_send=1 for exactly this cycle. Clear busy counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - If uart_tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. On reaching BUSY_TO: set to_err, clear lock, go to IDLE. The byte is dropped and not retried.
- WAIT_DONE: when uart_tx_busy=0, go to IDLE.
- req_ready is 0 in every state other than IDLE.
- to_err is set by a timeout and cleared by err_clr. If both occur in the same cycle, set wins.
- Counter width is clog2(BUSY_TO+1). It saturates and never wraps.
- rr_ptr wraps from NREQ-1 to 0.

## Timing
- Reset (rst=0, asynchronous) values:
  - state=IDLE; rr_ptr=0; lock clear
  - uart_send=0; uart_txd=8'h00; grant=0; active=0; to_err=0
- req_ready=0 while in reset.
- Acceptance in cycle T gives:
  - T+1: uart_send=1, with uart_txd valid from T+1 onward.
  - T+2: first WAIT_BUSY cycle.
- Timeout is flagged in the BUSY_TO-th WAIT_BUSY cycle without busy. to_err is visible the next cycle and state returns to IDLE.
- uart_tx_busy falling seen in WAIT_DONE at cycle D gives IDLE at D+1. The earliest next acceptance is D+1, so back-to-back bytes have a 1-cycle idle gap after busy drops.
- Reset mid-operation aborts immediately: lock and pending byte are lost. A byte already handed to UART_IP may still complete on the line.
- When a requester drops req_valid in IDLE before acceptance, the choice is re-evaluated next cycle with no state change.

## Test plan
- Single byte, no UART attached:
  - Stimulus: req0 sends 8'hA5 with last=1; bench model raises busy 3 cycles after send and holds it 20 cycles.
  - Required: req_ready[0] for 1 cycle; uart_send pulse at T+1; uart_txd=A5; IDLE one cycle after busy falls; grant=4'b0001.
- Round-robin:
  - Stimulus: all 4 requesters continuously valid, last=1.
  - Required: grant order 0,1,2,3,0,1; exactly one req_ready bit per acceptance.
- Packet lock:
  - Stimulus: req2 sends 3 bytes 11,22,33 (last on 33) while req0 and req1 are valid.
  - Required: 11,22,33 transmitted consecutively. Next grant goes to req3 if valid, else wraps to req0.
- Timeout:
  - Stimulus: busy held 0 with BUSY_TO=16.
  - Required: to_err rises 16 WAIT_BUSY cycles after send, lock cleared, next requester served. err_clr drops to_err. err_clr coincident with a new timeout leaves to_err=1.
- Reset mid-packet:
  - Stimulus: assert rst=0 in WAIT_DONE of byte 2 of a locked packet.
  - Required: all outputs at reset values asynchronously. After release, lowest-index valid requester from rr_ptr=0 is granted.
- Loopback integration:
  - Stimulus: UART_IP (config 8'hF7, divisor 64) TX looped to RX; 2 requesters each send 8 random bytes.
  - Required: RXD sequence matches acceptance order; no RxError.
